// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and types for the RX/TX datapaths.
// Contents: preamble/SFD byte values, CRC-32 polynomial/init/residue,
// field widths, receive FSM state type, bit-reflection helper.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

  localparam int unsigned ETH_LEN_W     = 11;
  localparam int unsigned ETH_PRE_CNT_W = 3;
  localparam int unsigned ETH_BAD_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    PAY  = 2'd2,
    DROP = 2'd3
  } eth_rx_state_e;

  // Bit-reverse a 32-bit word (LSB-first CRC uses the mirrored polynomial).
  function automatic logic [31:0] eth_reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational reflected CRC-32 update over one byte (LSB first).
// Ports:
//   crc        in  32 : current CRC register
//   data       in  8  : byte to absorb
//   crc_next_c out 32 : CRC after absorbing data (no final XOR)
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next_c
);

  localparam logic [31:0] POLY_R = eth_reflect32(ETH_CRC_POLY);

  // Eight unrolled shift/XOR steps; the byte is folded in up front.
  always_comb begin
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
    end
    crc_next_c = c;
  end

endmodule

// File: rtl/eth_rx_frame_check.sv
// Receive framing stage: strips preamble/SFD, checks FCS and length,
// emits payload bytes plus a one-cycle end-of-frame verdict.
// Config macro: ETH_RX_FCS_STRIP_EN -- when defined, a 4-byte delay line
// removes the FCS from the output stream; otherwise bytes pass through
// with one cycle of latency and the FCS is emitted.
// Ports:
//   rx_clk     in  1  : receive clock
//   rst        in  1  : asynchronous active-high reset
//   data       in  8  : received byte
//   data_valid in  1  : byte valid (RX_DV)
//   data_error in  1  : receive error on this byte (RX_ER)
//   out_data   out 8  : payload byte
//   out_valid  out 1  : out_data valid
//   out_sof    out 1  : first out_valid of a frame
//   out_eof    out 1  : end-of-frame strobe
//   out_good   out 1  : verdict, qualified by out_eof
//   frame_len  out 11 : bytes after SFD incl. FCS, qualified by out_eof
//   bad_cnt    out 16 : saturating bad-frame counter
module eth_rx_frame_check
  import eth_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic                     rx_clk,
  input  logic                     rst,
  input  logic [7:0]               data,
  input  logic                     data_valid,
  input  logic                     data_error,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic                     out_good,
  output logic [ETH_LEN_W-1:0]     frame_len,
  output logic [ETH_BAD_CNT_W-1:0] bad_cnt
);

  localparam logic [ETH_LEN_W-1:0]     MIN_LEN_L = ETH_LEN_W'(MIN_LEN);
  localparam logic [ETH_LEN_W-1:0]     MAX_LEN_L = ETH_LEN_W'(MAX_LEN);
  localparam logic [ETH_PRE_CNT_W-1:0] PRE_LAST  = ETH_PRE_CNT_W'(7);

  eth_rx_state_e              state_q, state_d;
  logic [ETH_PRE_CNT_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [31:0]                crc_q, crc_d, crc_nxt_c;
  logic [ETH_LEN_W-1:0]       len_q, len_d;
  logic                       err_q, err_d;

  logic [7:0]                 out_data_d;
  logic                       out_valid_d, out_sof_d, out_eof_d, out_good_d;
  logic [ETH_LEN_W-1:0]       frame_len_d;
  logic [ETH_BAD_CNT_W-1:0]   bad_cnt_d;

`ifdef ETH_RX_FCS_STRIP_EN
  logic [3:0][7:0]            dly_q, dly_d;
`endif

  eth_crc32_d8 u_crc (
    .crc        (crc_q),
    .data       (data),
    .crc_next_c (crc_nxt_c)
  );

  // State register; reset lands in DROP so a frame already in flight is ignored.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) state_q <= DROP;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (data_valid) state_d = (data == ETH_PREAMBLE) ? PRE : DROP;
      end
      PRE: begin
        if (!data_valid)                 state_d = IDLE;
        else if (data == ETH_PREAMBLE)   state_d = (pre_cnt_q == PRE_LAST) ? DROP : PRE;
        else if (data == ETH_SFD)        state_d = PAY;
        else                             state_d = DROP;
      end
      PAY: begin
        if (!data_valid) state_d = IDLE;
      end
      DROP: begin
        if (!data_valid) state_d = IDLE;
      end
      default: state_d = DROP;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    pre_cnt_d   = pre_cnt_q;
    crc_d       = crc_q;
    len_d       = len_q;
    err_d       = err_q;
    out_data_d  = out_data;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_eof_d   = 1'b0;
    out_good_d  = 1'b0;
    frame_len_d = frame_len;
    bad_cnt_d   = bad_cnt;
`ifdef ETH_RX_FCS_STRIP_EN
    dly_d       = dly_q;
`endif

    // Counter follows the registered verdict, hence one cycle after out_eof.
    if (out_eof && !out_good && (bad_cnt != '1)) begin
      bad_cnt_d = bad_cnt + ETH_BAD_CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        pre_cnt_d = ETH_PRE_CNT_W'(1);
      end
      PRE: begin
        if (data_valid) begin
          pre_cnt_d = pre_cnt_q + ETH_PRE_CNT_W'(1);
          if (data == ETH_SFD) begin
            crc_d = ETH_CRC_INIT;
            len_d = '0;
            err_d = 1'b0;
          end
        end
      end
      PAY: begin
        if (data_valid) begin
          crc_d = crc_nxt_c;
          len_d = (len_q == '1) ? len_q : len_q + ETH_LEN_W'(1);
          err_d = err_q | data_error;
`ifdef ETH_RX_FCS_STRIP_EN
          // Byte k arriving releases byte k-4; the last four are the FCS.
          dly_d = {dly_q[2:0], data};
          if ((len_q >= ETH_LEN_W'(4)) && (len_q < MAX_LEN_L)) begin
            out_valid_d = 1'b1;
            out_data_d  = dly_q[3];
            out_sof_d   = (len_q == ETH_LEN_W'(4));
          end
`else
          if (len_q < MAX_LEN_L) begin
            out_valid_d = 1'b1;
            out_data_d  = data;
            out_sof_d   = (len_q == '0);
          end
`endif
        end else begin
          out_eof_d   = 1'b1;
          frame_len_d = len_q;
          out_good_d  = (crc_q == ETH_CRC_RESIDUE) && !err_q &&
                        (len_q >= MIN_LEN_L) && (len_q <= MAX_LEN_L);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      crc_q     <= ETH_CRC_INIT;
      len_q     <= '0;
      err_q     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_good  <= 1'b0;
      frame_len <= '0;
      bad_cnt   <= '0;
`ifdef ETH_RX_FCS_STRIP_EN
      dly_q     <= '0;
`endif
    end else begin
      pre_cnt_q <= pre_cnt_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      err_q     <= err_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_sof   <= out_sof_d;
      out_eof   <= out_eof_d;
      out_good  <= out_good_d;
      frame_len <= frame_len_d;
      bad_cnt   <= bad_cnt_d;
`ifdef ETH_RX_FCS_STRIP_EN
      dly_q     <= dly_d;
`endif
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_check.sv
// Scoreboard bench for eth_rx_frame_check: stimulus pushes expected bytes and
// end-of-frame records; a negedge monitor pops and compares. Honors
// ETH_RX_FCS_STRIP_EN for the expected byte stream.
module tb_eth_rx_frame_check;

  localparam int unsigned MAX_LEN = 1518;

  logic        rx_clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        data_valid;
  logic        data_error;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        out_good;
  logic [10:0] frame_len;
  logic [15:0] bad_cnt;

  always #5 rx_clk = ~rx_clk;

  eth_rx_frame_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .rx_clk     (rx_clk),
    .rst        (rst),
    .data       (data),
    .data_valid (data_valid),
    .data_error (data_error),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_good   (out_good),
    .frame_len  (frame_len),
    .bad_cnt    (bad_cnt)
  );

  typedef struct packed { logic [7:0] d; logic sof; } exp_byte_t;
  typedef struct packed { logic good; logic [10:0] len; } exp_eof_t;

  exp_byte_t  byte_q[$];
  exp_eof_t   eof_q[$];
  logic [7:0] frm[$];
  int         checks = 0;
  int         failures = 0;
  int         exp_bad = 0;
  bit         bad_chk_pending = 1'b0;
  exp_byte_t  mon_b;
  exp_eof_t   mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Independent bit-serial reference CRC (reflected polynomial).
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Payload bytes start, start+1, ... followed by a correct FCS (LSB first).
  task automatic build_frame(input int n_pay, input logic [7:0] start);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n_pay; i++) begin
      b = start + 8'(i);
      frm.push_back(b);
      c = crc_byte(c, b);
    end
    c = ~c;
    for (int j = 0; j < 4; j++) frm.push_back(c[8*j +: 8]);
  endtask

  // Expected emitted bytes when the first n_seen frame bytes are sampled.
  task automatic push_bytes(input int n_seen);
    for (int k = 0; k < n_seen; k++) begin
`ifdef ETH_RX_FCS_STRIP_EN
      if (k >= 4 && k < MAX_LEN) byte_q.push_back('{d: frm[k-4], sof: (k == 4)});
`else
      if (k < MAX_LEN) byte_q.push_back('{d: frm[k], sof: (k == 0)});
`endif
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    @(posedge rx_clk);
    #1;
    data = d;
    data_valid = dv;
    data_error = er;
  endtask

  task automatic send_frame(input int err_idx, input logic end_err, input logic exp_good,
                            input int gap);
    push_bytes(frm.size());
    eof_q.push_back('{good: exp_good, len: 11'(frm.size())});
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int k = 0; k < frm.size(); k++) drive(frm[k], 1'b1, (k == err_idx));
    drive(8'h00, 1'b0, end_err);
    repeat (gap - 1) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_data"},  32'(out_data),  32'h0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_out_sof"},   32'(out_sof),   32'h0);
    chk({tag, "_out_eof"},   32'(out_eof),   32'h0);
    chk({tag, "_out_good"},  32'(out_good),  32'h0);
    chk({tag, "_frame_len"}, 32'(frame_len), 32'h0);
    chk({tag, "_bad_cnt"},   32'(bad_cnt),   32'h0);
  endtask

  // Monitor: compare every presented byte / end-of-frame against the queues.
  always @(negedge rx_clk) begin
    if (!rst) begin
      if (bad_chk_pending) begin
        chk("bad_cnt", 32'(bad_cnt), 32'(exp_bad));
        bad_chk_pending = 1'b0;
      end
      if (out_valid) begin
        if (byte_q.size() == 0) begin
          chk("unexpected_byte", 32'(out_data), 32'h100);
        end else begin
          mon_b = byte_q.pop_front();
          chk("byte_data", 32'(out_data), 32'(mon_b.d));
          chk("byte_sof", 32'(out_sof), 32'(mon_b.sof));
        end
      end
      if (out_eof) begin
        chk("eof_no_valid", 32'(out_valid), 32'h0);
        if (eof_q.size() == 0) begin
          chk("unexpected_eof", 32'(out_eof), 32'h0);
        end else begin
          mon_e = eof_q.pop_front();
          chk("eof_good", 32'(out_good), 32'(mon_e.good));
          chk("eof_len", 32'(frame_len), 32'(mon_e.len));
          if (!mon_e.good) exp_bad++;
          bad_chk_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    rst = 1'b1;
    data = 8'h00;
    data_valid = 1'b0;
    data_error = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) drive(8'h00, 1'b0, 1'b0);

    // Good 64-byte frame; data_error asserted on the falling-DV cycle is ignored.
    build_frame(60, 8'h00);
    send_frame(-1, 1'b1, 1'b1, 1);

    // Corrupted last FCS byte, back-to-back.
    build_frame(60, 8'h00);
    frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
    send_frame(-1, 1'b0, 1'b0, 2);

    // data_error on payload byte 10 with correct CRC.
    build_frame(60, 8'h00);
    send_frame(10, 1'b0, 1'b0, 2);

    // Broken preamble: whole frame dropped.
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h5D, 1'b1, 1'b0);
    repeat (5) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(8'(i), 1'b1, 1'b0);
    repeat (2) drive(8'h00, 1'b0, 1'b0);

    // Eight preamble bytes: too long, frame dropped.
    build_frame(60, 8'h00);
    repeat (8) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int k = 0; k < frm.size(); k++) drive(frm[k], 1'b1, 1'b0);
    repeat (2) drive(8'h00, 1'b0, 1'b0);

    // Next good frame is accepted.
    build_frame(60, 8'h80);
    send_frame(-1, 1'b0, 1'b1, 2);

    // Runt: 20 bytes with valid FCS.
    build_frame(16, 8'hA0);
    send_frame(-1, 1'b0, 1'b0, 2);

    // Oversize: 1600 bytes, output truncated.
    build_frame(1596, 8'h10);
    send_frame(-1, 1'b0, 1'b0, 3);

    // Reset at payload byte 30, released while DV still high.
    build_frame(60, 8'h40);
    push_bytes(30);
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) drive(frm[k], 1'b1, 1'b0);
    drive(frm[30], 1'b1, 1'b0);
    @(negedge rx_clk);
    #1;
    rst = 1'b1;
    exp_bad = 0;
    #1;
    check_all_zero("midreset");
    drive(frm[31], 1'b1, 1'b0);
    drive(frm[32], 1'b1, 1'b0);
    rst = 1'b0;
    for (int k = 33; k < 38; k++) drive(frm[k], 1'b1, 1'b0);
    repeat (3) drive(8'h00, 1'b0, 1'b0);

    // Good frame after reset.
    build_frame(60, 8'h33);
    send_frame(-1, 1'b0, 1'b1, 3);

    wait_cnt = 0;
    while ((byte_q.size() != 0 || eof_q.size() != 0 || bad_chk_pending) && wait_cnt < 100) begin
      @(posedge rx_clk);
      wait_cnt++;
    end
    repeat (3) @(posedge rx_clk);
    chk("byte_q_drained", 32'(byte_q.size()), 32'h0);
    chk("eof_q_drained", 32'(eof_q.size()), 32'h0);
    chk("final_bad_cnt", 32'(bad_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_check.md
# eth_rx_frame_check

Receive-side framing stage that sits directly downstream of the RGMII receiver, in the `rx_clk` domain. It consumes the byte stream `data`/`data_valid`/`data_error`, strips preamble and SFD, and checks the Ethernet FCS (CRC-32) and frame length. It emits a clean payload byte stream to the MAC/packet logic, plus a one-cycle end-of-frame status with good/bad verdict, length and a bad-frame counter.

## Interface
- `MIN_LEN`, 64: minimum legal frame length in bytes, DA through FCS inclusive.
- `MAX_LEN`, 1518: maximum legal frame length in bytes, DA through FCS inclusive; must be < 2047.

Ports:
- `rx_clk` in 1: receive clock, the single clock of the block.
- `rst` in 1: reset, asynchronous, active-high.
- `data` in 8: received byte.
- `data_valid` in 1: byte valid (RX_DV).
- `data_error` in 1: receive error on this byte (RX_ER).
- `out_data` out 8: payload byte.
- `out_valid` out 1: `out_data` valid.
- `out_sof` out 1: with first `out_valid` of a frame.
- `out_eof` out 1: one-cycle end-of-frame strobe; never coincident with `out_valid`.
- `out_good` out 1: frame verdict, valid only while `out_eof` is high.
- `frame_len` out 11: bytes received after SFD (incl. FCS), saturating at 2047; valid with `out_eof`.
- `bad_cnt` out 16: count of bad frames, saturating at 0xFFFF.

## Operation
- Reset: all outputs 0, state `DROP`.
  - `DROP` is used so that a frame already in progress when reset releases is ignored.
- FSM states and transitions:
  - `IDLE`: on `data_valid` with `data`==0x55, go to `PRE` with preamble count 1. On `data_valid` with any other byte, go to `DROP`.
  - `PRE`:
    - 0x55 increments the count; an 8th 0x55 goes to `DROP`.
    - 0xD5 (SFD) goes to `PAY`.
    - Any other byte goes to `DROP`.
    - `data_valid` low goes to `IDLE`.
  - `PAY`: every valid byte is counted and fed to the CRC. `data_error` on any byte sets a sticky error flag. The first cycle with `data_valid` low ends the frame and goes to `IDLE`, issuing `out_eof`.
  - `DROP`: wait for `data_valid` low, then go to `IDLE`. No output and no `out_eof`.
- CRC:
  - Reflected CRC-32, polynomial 0x04C11DB7, initialised to 0xFFFFFFFF at SFD.
  - Updated over all payload bytes including FCS, with no final XOR.
  - The CRC is OK when the register equals the residue 0xDEBB20E3 at frame end.
- `out_good` = CRC OK AND no `data_error` AND `MIN_LEN` ≤ `frame_len` ≤ `MAX_LEN`. `bad_cnt` increments on each `out_eof` with `out_good`=0.
- Byte emission stops after `MAX_LEN` bytes; reception continues to the end of the frame, and the frame is reported bad.
- Frames of fewer than 5 bytes with FCS stripping, or 0 bytes without it, produce no `out_valid`. They still produce `out_eof` with `out_good`=0.
- Simultaneous events: `data_valid` falling while `data_error` is high counts neither as a byte nor as an error.

## Timing
- Without stripping: payload byte k appears on `out_data` one cycle after it is sampled.
- With stripping: byte k appears one cycle after byte k+4 is sampled. The 4 FCS bytes are never emitted.
- If `data_valid` is first sampled low at cycle T, then `out_eof`, `out_good` and `frame_len` are presented at T+1. `bad_cnt` updates at T+2.
- Back-to-back frames: a new preamble may start at T+1; state is cleared on SFD.
- Asynchronous reset mid-frame: the frame in flight is discarded and no `out_eof` is produced.

## Configuration
- `ETH_RX_FCS_STRIP_EN` defined:
  - 4-byte delay line; FCS removed from the output stream.
  - `out_sof` is on payload byte 0 (emitted when byte 4 arrives).
- Undefined:
  - 1-cycle pass-through; FCS bytes are emitted as the last 4 `out_valid` bytes.
- `frame_len` and the length checks always include the FCS.

## Structure
- Shared package `eth_pkg`:
  - Constants `ETH_PREAMBLE`=0x55, `ETH_SFD`=0xD5, `ETH_CRC_POLY`, `ETH_CRC_INIT`, `ETH_CRC_RESIDUE`.
  - FSM state type {`IDLE`, `PRE`, `PAY`, `DROP`}.
- One sub-module, `eth_crc32_d8`: combinational next-CRC from the 32-bit CRC and an 8-bit byte, reused later by the TX path.

## Test plan
- 7×0x55, 0xD5, then 60 payload bytes 0x00..0x3B plus correct FCS -> 60 bytes out (64 if unstripped), `out_sof` on 0x00, `out_eof` with `out_good`=1, `frame_len`=64, `bad_cnt`=0.
- Same frame with the last FCS byte XOR 0x01 -> `out_good`=0, `bad_cnt`=1.
- Same frame with `data_error` on payload byte 10 -> `out_good`=0 although the CRC is correct.
- Preamble 0x55,0x55,0x5D,… -> no `out_valid`, no `out_eof`; the next good frame is accepted normally.
- 20-byte frame with correct FCS -> `out_good`=0, `frame_len`=20. 1600-byte frame -> output truncated at 1518 bytes (1514 stripped), `frame_len`=1600, `out_good`=0.
- Assert `rst` at payload byte 30, release while `data_valid` is still high -> no `out_eof` for that frame, all outputs 0. The following frame gives `out_good`=1.
